// File: rtl/parking_entry_ctrl.sv
// Entry-gate controller: car detection, passcode check, occupancy tracking.
// Emits a one-cycle open_signal pulse to the downstream door blinker.
// Optional build macro PARKING_LOCKOUT_EN adds a wrong-code attempts counter
// and a timed LOCKOUT state; without it every mismatch simply denies.
module parking_entry_ctrl #(
    parameter int unsigned        CAPACITY     = 8,
    parameter int unsigned        CNT_W        = 4,
    parameter int unsigned        CODE_W       = 4,
    parameter logic [CODE_W-1:0]  PASSCODE     = 4'hA,
    parameter int unsigned        MAX_TRIES    = 3,
    parameter int unsigned        CODE_TIMEOUT = 20,
    parameter int unsigned        HOLD_CYCLES  = 22,
    parameter int unsigned        DENY_CYCLES  = 4,
    parameter int unsigned        LOCK_CYCLES  = 60
) (
    input  logic              clk_2Hz,
    input  logic              reset,
    input  logic              entry_req,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    input  logic              car_exit,
    output logic              open_signal,
    output logic [CNT_W-1:0]  free_slots,
    output logic              full,
    output logic              deny_led,
    output logic              lockout
);

    // One shared timer serves every timed state, so size it for the longest.
    localparam int unsigned MAX_A = (CODE_TIMEOUT > HOLD_CYCLES) ? CODE_TIMEOUT : HOLD_CYCLES;
    localparam int unsigned MAX_B = (DENY_CYCLES > LOCK_CYCLES) ? DENY_CYCLES : LOCK_CYCLES;
    localparam int unsigned TMR_W = $clog2(((MAX_A > MAX_B) ? MAX_A : MAX_B) + 1);
    localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CODE,
        S_GRANT,
        S_HOLD,
        S_DENY,
        S_LOCKOUT
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               entry_prev_q, entry_prev_d;
    logic [CNT_W-1:0]   occ_q, occ_d;
    logic [CNT_W-1:0]   free_slots_q, free_slots_d;
    logic               full_q, full_d;
    logic               open_q, open_d;
    logic               entry_rise;
    logic               occ_inc, occ_dec;

`ifdef PARKING_LOCKOUT_EN
    localparam int unsigned ATT_W = $clog2(MAX_TRIES + 1);
    logic [ATT_W-1:0]   attempts_q, attempts_d;
`else
    logic               unused_tries;
    assign unused_tries = (MAX_TRIES == 0);
`endif

    assign entry_rise = entry_req && !entry_prev_q;

    // Next-state, timer, attempts and open-pulse logic.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q + 1'b1;
        entry_prev_d = entry_req;
        open_d       = (state_q == S_GRANT);
`ifdef PARKING_LOCKOUT_EN
        attempts_d   = attempts_q;
`endif
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (entry_rise) begin
                    state_d = (occ_q == CAP_C) ? S_DENY : S_WAIT_CODE;
                end
            end
            S_WAIT_CODE: begin
                if (code_valid) begin
                    timer_d = '0;
                    if (code_in == PASSCODE) begin
                        state_d = S_GRANT;
                    end else begin
`ifdef PARKING_LOCKOUT_EN
                        attempts_d = attempts_q + 1'b1;
                        state_d    = (attempts_q == ATT_W'(MAX_TRIES - 1)) ? S_LOCKOUT : S_DENY;
`else
                        state_d    = S_DENY;
`endif
                    end
                end else if (timer_q == TMR_W'(CODE_TIMEOUT - 1)) begin
                    timer_d = '0;
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                timer_d = '0;
                state_d = S_HOLD;
`ifdef PARKING_LOCKOUT_EN
                attempts_d = '0;
`endif
            end
            S_HOLD: begin
                if (timer_q == TMR_W'(HOLD_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = S_IDLE;
                end
            end
            S_DENY: begin
                if (timer_q == TMR_W'(DENY_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (timer_q == TMR_W'(LOCK_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = S_IDLE;
`ifdef PARKING_LOCKOUT_EN
                    attempts_d = '0;
`endif
                end
            end
            default: begin
                timer_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Occupancy bookkeeping; an exit coinciding with a grant cancels out.
    always_comb begin
        occ_d   = occ_q;
        occ_inc = (state_q == S_GRANT) && (occ_q != CAP_C);
        occ_dec = car_exit && (occ_q != '0);
        case ({occ_inc, occ_dec})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
        free_slots_d = CAP_C - occ_q;
        full_d       = (occ_q == CAP_C);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_2Hz) begin
        if (reset) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            entry_prev_q <= 1'b0;
            occ_q        <= '0;
            free_slots_q <= CAP_C;
            full_q       <= 1'b0;
            open_q       <= 1'b0;
`ifdef PARKING_LOCKOUT_EN
            attempts_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            entry_prev_q <= entry_prev_d;
            occ_q        <= occ_d;
            free_slots_q <= free_slots_d;
            full_q       <= full_d;
            open_q       <= open_d;
`ifdef PARKING_LOCKOUT_EN
            attempts_q   <= attempts_d;
`endif
        end
    end

    assign open_signal = open_q;
    assign free_slots  = free_slots_q;
    assign full        = full_q;
    assign deny_led    = (state_q == S_DENY);
`ifdef PARKING_LOCKOUT_EN
    assign lockout     = (state_q == S_LOCKOUT);
`else
    assign lockout     = 1'b0;
`endif

endmodule
